// File: rtl/la_oai_pipe.sv
// Pipelined Or-And-Invert reduction: N groups of M W-bit inputs, per bit
// z = ~&(|group), followed by a STAGES-deep bubble-collapsing valid/ready pipeline.
module la_oai_pipe #(
  parameter int unsigned N      = 2,
  parameter int unsigned M      = 3,
  parameter int unsigned W      = 1,
  parameter int unsigned STAGES = 2,
  parameter              PROP   = "DEFAULT"
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*M*W-1:0]   a,
  output logic               z_valid,
  input  logic               z_ready,
  output logic [W-1:0]       z
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("la_oai_pipe(%s): STAGES=%0d outside 1..4", PROP, STAGES);
  end

  logic [W-1:0]      oai;
  logic [STAGES-1:0] vld_q, vld_d, adv, up_vld;
  logic [W-1:0]      dat_q  [STAGES];
  logic [W-1:0]      dat_d  [STAGES];
  logic [W-1:0]      up_dat [STAGES];

  always_comb begin
    logic [W-1:0] and_acc;
    logic [W-1:0] or_acc;
    and_acc = '1;
    or_acc  = '0;
    for (int unsigned g = 0; g < N; g++) begin
      or_acc = '0;
      for (int unsigned i = 0; i < M; i++) begin
        or_acc = or_acc | a[((g*M)+i)*W +: W];
      end
      and_acc = and_acc & or_acc;
    end
    oai = ~and_acc;
  end

  // Advance enables ripple back from z_ready; an empty stage always advances,
  // which lets later inputs collapse into bubbles while the output is stalled.
  always_comb begin
    adv[STAGES-1] = !vld_q[STAGES-1] || z_ready;
    for (int unsigned k = STAGES-1; k > 0; k--) begin
      adv[k-1] = !vld_q[k-1] || adv[k];
    end
    up_vld    = STAGES'({vld_q, in_valid});
    up_dat[0] = oai;
    for (int unsigned k = 1; k < STAGES; k++) begin
      up_dat[k] = dat_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      vld_d[k] = adv[k] ? up_vld[k] : vld_q[k];
      dat_d[k] = adv[k] ? up_dat[k] : dat_q[k];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign in_ready = adv[0];
  assign z_valid  = vld_q[STAGES-1];
  assign z        = dat_q[STAGES-1];

endmodule

// File: doc/la_oai_pipe.md
Name: la_oai_pipe

Overview:
- Parametrised, pipelined Or-And-Invert reduction: N groups of M inputs, each W bits wide.
- Per bit: z = ~(OR(group0) & OR(group1) & ... & OR(groupN-1)).
- Result travels through a STAGES-deep elastic valid/ready pipeline, so wide OAI trees can sit on timing-critical datapaths with backpressure.
- Stdlib block; the OAI function is fixed, and the parameters set shape and latency.

Parameters:
- N, 2, number of AND-ed groups (>=1)
- M, 3, inputs OR-ed per group (>=1)
- W, 1, bit width of each input and of z (bitwise operation)
- STAGES, 2, pipeline register stages (1..4); latency in cycles when not stalled
- PROP, "DEFAULT", implementation property string, passed through untouched

Ports:
- clk  input  1  clock, all state on rising edge
- nreset  input  1  asynchronous active-low reset
- in_valid  input  1  operand vector a is valid this cycle
- in_ready  output  1  pipeline accepts a this cycle
- a  input  N*M*W  operands; group g, input i, bit b at a[((g*M)+i)*W+b]
- z_valid  output  1  z holds a valid result
- z_ready  input  1  consumer accepts z this cycle
- z  output  W  OAI result of the oldest in-flight transaction

Behaviour:
- Function per bit b: z[b] = ~(AND over g of (OR over i of a[g][i][b])).
  - N=1 reduces to NOR.
  - M=1 reduces to NAND.
- Computation:
  - The function is evaluated combinationally on a at the input.
  - Only the W-bit result plus a valid flag is registered in each stage.
  - Stage k holds vld[k] and dat[k][W-1:0]; the last stage drives z_valid/z.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: z_valid & z_ready.
- Stage advance rule, bubble-collapsing:
  - Stage k loads from stage k-1 (stage 0 loads from the input) when !vld[k] | (stage k+1 loads or k is last and z_ready).
  - Stage k's vld becomes the upstream valid.
- in_ready = !vld[0] | stage 0 advancing.
  - in_ready is combinational from z_ready through the chain.
  - No combinational path from a or in_valid to in_ready.
- Latency: a result accepted at cycle t has z_valid at cycle t+STAGES if no stall.
- Throughput: 1 transaction/cycle with z_ready held high.
- Backpressure:
  - While z_valid & !z_ready, z and z_valid hold stable.
  - Upstream stages fill bubbles, then in_ready falls.
  - At most STAGES transactions are in flight.
- Ordering is strict FIFO; no transaction is dropped or duplicated.
- Simultaneous input and output transfer with all stages full: both complete and occupancy is unchanged.
- in_valid may drop without a transfer; a is don't-care when in_valid=0.
- Data registers load only on stage advance; a stalled stage never changes.
- Reset, asserted asynchronously at any time including mid-stream:
  - All vld[k] = 0 and dat[k] = 0 immediately.
  - Reset values: z_valid=0, z=0, in_ready=1 once nreset is released.
  - In-flight transactions are discarded.
  - The first clk edge after release may accept input.
- Out-of-range STAGES (<1 or >4) is a compile-time error (generate-time check).

Test Plan:
- Truth table, N=2, M=3, W=1, STAGES=2, z_ready=1:
  - Stream all 64 a values -> z matches ~((a0|a1|a2)&(b0|b1|b2)).
  - e.g. a=6'b001_001 -> z=0; a=6'b000_111 -> z=1.
  - Each result appears exactly 2 cycles after its accept.
- Throughput: 16 back-to-back accepts -> z_valid high 16 consecutive cycles starting at cycle 2; in_ready constantly 1.
- Backpressure, STAGES=3:
  - Hold z_ready=0 with in_valid=1 -> exactly 3 accepts, then in_ready=0.
  - z stable; releasing z_ready drains in order with no loss.
  - in_ready re-asserts the same cycle z_ready=1.
- Bubbles: random in_valid (50%) and random z_ready (50%) over 1000 cycles, compared against a scoreboard FIFO -> zero mismatches, order preserved.
- Reset mid-operation: pipeline full, nreset asserted between edges -> z_valid=0 and z=0 immediately; after release in_ready=1 and no stale results emerge.
- Vector/shape, N=4, M=2, W=8, STAGES=1:
  - All inputs 8'h00 except group 0 = 8'h0F and groups 1..3 = 8'hFF -> z=8'hF0, 1-cycle latency.
  - N=1, M=1 -> z=~a.
